// File: rtl/cpu_sram_arbiter.sv
// Shares one SRAM-like bus between the instruction-fetch and data-memory ports.
// One transaction in flight, data wins ties, each side keeps a tagged return buffer.
module cpu_sram_arbiter (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  input  logic        i_inst_consume,
  output logic [31:0] o_inst_rdata,
  output logic        o_inst_stall,
  input  logic        i_data_en,
  input  logic        i_data_we,
  input  logic [1:0]  i_data_size,
  input  logic [3:0]  i_data_sel,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  input  logic        i_data_consume,
  output logic [31:0] o_data_rdata,
  output logic        o_data_stall,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [1:0]  o_bus_size,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_addr_ok,
  input  logic        i_bus_data_ok,
  input  logic [31:0] i_bus_rdata
);
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_I_ADDR = 3'd1;
  localparam logic [2:0] S_I_WAIT = 3'd2;
  localparam logic [2:0] S_D_ADDR = 3'd3;
  localparam logic [2:0] S_D_WAIT = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_i_done;
  logic          r_d_done;
  logic [AW-1:0] r_i_tag;
  logic [AW-1:0] r_d_tag;
  logic [DW-1:0] r_inst_rdata;
  logic [DW-1:0] r_data_rdata;
  logic          r_bus_req;
  logic          r_bus_wr;
  logic [1:0]    r_bus_size;
  logic [3:0]    r_bus_sel;
  logic [AW-1:0] r_bus_addr;
  logic [DW-1:0] r_bus_wdata;

  logic w_i_hit;
  logic w_d_hit;
  logic w_i_pend;
  logic w_d_pend;
  logic w_i_issue;
  logic w_d_issue;
  logic w_i_fill;
  logic w_d_fill;
  logic w_addr_acc;

  assign w_i_hit    = r_i_done & (r_i_tag == i_inst_addr);
  assign w_d_hit    = r_d_done & (r_d_tag == i_data_addr);
  assign w_i_pend   = i_inst_req & ~w_i_hit;
  assign w_d_pend   = i_data_en & ~w_d_hit;
  assign w_d_issue  = (r_state == S_IDLE) & w_d_pend;
  assign w_i_issue  = (r_state == S_IDLE) & ~w_d_pend & w_i_pend;
  assign w_i_fill   = (r_state == S_I_WAIT) & i_bus_data_ok;
  assign w_d_fill   = (r_state == S_D_WAIT) & i_bus_data_ok;
  assign w_addr_acc = ((r_state == S_I_ADDR) | (r_state == S_D_ADDR)) & i_bus_addr_ok;

  assign o_inst_stall = w_i_pend;
  assign o_data_stall = w_d_pend;
  assign o_inst_rdata = r_inst_rdata;
  assign o_data_rdata = r_data_rdata;
  assign o_bus_req    = r_bus_req;
  assign o_bus_wr     = r_bus_wr;
  assign o_bus_size   = r_bus_size;
  assign o_bus_sel    = r_bus_sel;
  assign o_bus_addr   = r_bus_addr;
  assign o_bus_wdata  = r_bus_wdata;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_d_pend)      w_state_nxt = S_D_ADDR;
        else if (w_i_pend) w_state_nxt = S_I_ADDR;
      end
      S_I_ADDR: if (i_bus_addr_ok) w_state_nxt = S_I_WAIT;
      S_I_WAIT: if (i_bus_data_ok) w_state_nxt = S_IDLE;
      S_D_ADDR: if (i_bus_addr_ok) w_state_nxt = S_D_WAIT;
      S_D_WAIT: if (i_bus_data_ok) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Request fields are captured on issue and held until the next issue
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bus_req   <= 1'b0;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'd0;
      r_bus_sel   <= 4'd0;
      r_bus_addr  <= AW'(0);
      r_bus_wdata <= DW'(0);
    end else if (w_d_issue) begin
      r_bus_req   <= 1'b1;
      r_bus_wr    <= i_data_we;
      r_bus_size  <= i_data_size;
      r_bus_sel   <= i_data_sel;
      r_bus_addr  <= i_data_addr;
      r_bus_wdata <= i_data_wdata;
    end else if (w_i_issue) begin
      r_bus_req   <= 1'b1;
      r_bus_wr    <= 1'b0;
      r_bus_size  <= 2'd2;
      r_bus_sel   <= 4'hF;
      r_bus_addr  <= i_inst_addr;
    end else if (w_addr_acc) begin
      r_bus_req   <= 1'b0;
    end
  end

  // Issuing drops the old word so a retagged buffer never hits early
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i_done     <= 1'b0;
      r_i_tag      <= AW'(0);
      r_inst_rdata <= DW'(0);
    end else if (w_i_issue) begin
      r_i_done     <= 1'b0;
      r_i_tag      <= i_inst_addr;
    end else if (w_i_fill) begin
      r_i_done     <= 1'b1;
      r_inst_rdata <= i_bus_rdata;
    end else if (i_inst_consume & w_i_hit) begin
      r_i_done     <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_d_done     <= 1'b0;
      r_d_tag      <= AW'(0);
      r_data_rdata <= DW'(0);
    end else if (w_d_issue) begin
      r_d_done     <= 1'b0;
      r_d_tag      <= i_data_addr;
    end else if (w_d_fill) begin
      r_d_done     <= 1'b1;
      r_data_rdata <= i_bus_rdata;
    end else if (i_data_consume & w_d_hit) begin
      r_d_done     <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Bench for cpu_sram_arbiter: latency-programmable bus slave plus queue scoreboards
// for bus requests and delivered words, with directed cycle checks around them.
module tb_cpu_sram_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_consume, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_en, data_we, data_consume, data_stall;
  logic [1:0]  data_size;
  logic [3:0]  data_sel;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, addr_ok, data_ok;
  logic [1:0]  bus_size;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        exp_req[$];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];
  int          addr_lat = 0;
  int          data_lat = 0;
  int          n_err = 0;
  int          n_chk = 0;

  cpu_sram_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_inst_req(inst_req), .i_inst_addr(inst_addr), .i_inst_consume(inst_consume),
    .o_inst_rdata(inst_rdata), .o_inst_stall(inst_stall),
    .i_data_en(data_en), .i_data_we(data_we), .i_data_size(data_size),
    .i_data_sel(data_sel), .i_data_addr(data_addr), .i_data_wdata(data_wdata),
    .i_data_consume(data_consume), .o_data_rdata(data_rdata), .o_data_stall(data_stall),
    .o_bus_req(bus_req), .o_bus_wr(bus_wr), .o_bus_size(bus_size), .o_bus_sel(bus_sel),
    .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata),
    .i_bus_addr_ok(addr_ok), .i_bus_data_ok(data_ok), .i_bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic wr, input logic [1:0] sz, input logic [3:0] sel,
                          input logic [31:0] a, input logic [31:0] wd);
    req_t r;
    r.wr = wr; r.size = sz; r.sel = sel; r.addr = a; r.wdata = wd;
    exp_req.push_back(r);
  endtask

  // Steps cycles until both requests are dropped; a request is dropped the cycle after delivery
  task automatic run(input int max_cyc, output int i_st, output int d_st, output int breq);
    logic i_drop, d_drop;
    i_st = 0; d_st = 0; breq = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (!inst_req && !data_en) return;
      #1;
      i_drop = inst_req && !inst_stall;
      d_drop = data_en && !data_stall;
      if (inst_req && inst_stall) i_st++;
      if (data_en && data_stall) d_st++;
      if (bus_req) breq++;
      tick();
      if (i_drop) inst_req = 1'b0;
      if (d_drop) data_en = 1'b0;
    end
    chk("run_timeout", 64'(inst_req | data_en), 64'd0);
  endtask

  // Bus slave: addr_ok after addr_lat request cycles, data_ok after data_lat wait cycles
  initial begin
    int          a_cnt;
    int          w_cnt;
    logic        in_wait;
    logic [31:0] a_addr;
    req_t        e;
    a_cnt = 0; w_cnt = 0; in_wait = 1'b0; a_addr = 32'd0;
    addr_ok = 1'b0; data_ok = 1'b0; bus_rdata = 32'd0;
    forever begin
      tick();
      addr_ok = 1'b0;
      data_ok = 1'b0;
      if (rst) begin
        a_cnt = 0; w_cnt = 0; in_wait = 1'b0;
      end else if (in_wait) begin
        if (w_cnt == data_lat) begin
          data_ok = 1'b1; bus_rdata = mem_word(a_addr); in_wait = 1'b0; w_cnt = 0;
        end else w_cnt++;
      end else if (bus_req) begin
        if (a_cnt == addr_lat) begin
          addr_ok = 1'b1; a_cnt = 0; in_wait = 1'b1; a_addr = bus_addr;
          chk("sb_req_nonempty", 64'(exp_req.size() != 0), 64'd1);
          if (exp_req.size() != 0) begin
            e = exp_req.pop_front();
            chk("bus_fields", 64'({bus_wr, bus_size, bus_sel, bus_addr}),
                64'({e.wr, e.size, e.sel, e.addr}));
            if (e.wr) chk("bus_wdata", 64'(bus_wdata), 64'(e.wdata));
          end
        end else a_cnt++;
      end
    end
  end

  // Delivery monitor: compare the word at the cycle the pipeline consumes it
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (!rst && inst_req && !inst_stall && inst_consume) begin
        chk("sb_i_nonempty", 64'(exp_i.size() != 0), 64'd1);
        if (exp_i.size() != 0) chk("inst_rdata", 64'(inst_rdata), 64'(exp_i.pop_front()));
      end
      if (!rst && data_en && !data_we && !data_stall && data_consume) begin
        chk("sb_d_nonempty", 64'(exp_d.size() != 0), 64'd1);
        if (exp_d.size() != 0) chk("data_rdata", 64'(data_rdata), 64'(exp_d.pop_front()));
      end
    end
  end

  initial begin
    int i_st, d_st, breq;
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'd0; inst_consume = 1'b1;
    data_en = 1'b0; data_we = 1'b0; data_size = 2'd0; data_sel = 4'd0;
    data_addr = 32'd0; data_wdata = 32'd0; data_consume = 1'b1;
    tick(); tick();
    #1;
    chk("rst_bus_req", 64'(bus_req), 64'd0);
    chk("rst_bus_fields", 64'({bus_wr, bus_size, bus_sel, bus_addr}), 64'd0);
    chk("rst_bus_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_rdata", 64'({inst_rdata, data_rdata}), 64'd0);
    data_en = 1'b1;
    #1;
    chk("rst_stall_follows", 64'(data_stall), 64'd1);
    data_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Single fetch, minimum latency
    inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
    push_req(1'b0, 2'd2, 4'hF, 32'hBFC0_0000, 32'd0);
    exp_i.push_back(32'h2408_0001);
    #1;
    chk("f_c0_stall", 64'(inst_stall), 64'd1);
    chk("f_c0_req", 64'(bus_req), 64'd0);
    tick(); #1;
    chk("f_c1_req", 64'({bus_req, inst_stall}), 64'b11);
    chk("f_c1_addr", 64'(bus_addr), 64'hBFC0_0000);
    tick(); #1;
    chk("f_c2", 64'({bus_req, inst_stall}), 64'b01);
    tick(); #1;
    chk("f_c3_stall", 64'(inst_stall), 64'd0);
    chk("f_c3_rdata", 64'(inst_rdata), 64'h2408_0001);
    tick(); #1;
    chk("f_c4_consumed", 64'(inst_stall), 64'd1);
    inst_req = 1'b0;
    tick();

    // Contention: load wins, fetch follows
    data_en = 1'b1; data_we = 1'b0; data_size = 2'd2; data_sel = 4'hF; data_addr = 32'h8000_0010;
    inst_req = 1'b1; inst_addr = 32'h0000_1000;
    push_req(1'b0, 2'd2, 4'hF, 32'h8000_0010, 32'd0);
    push_req(1'b0, 2'd2, 4'hF, 32'h0000_1000, 32'd0);
    exp_d.push_back(mem_word(32'h8000_0010));
    exp_i.push_back(mem_word(32'h0000_1000));
    #1;
    chk("c_c0_stalls", 64'({inst_stall, data_stall}), 64'b11);
    tick(); #1;
    chk("c_c1_addr", 64'({bus_req, bus_addr}), 64'h1_8000_0010);
    run(40, i_st, d_st, breq);
    chk("c_i_stall_cyc", 64'(i_st + 1), 64'd6);
    chk("c_d_stall_cyc", 64'(d_st + 1), 64'd3);
    chk("c_breq_cyc", 64'(breq), 64'd2);

    // Store with three cycles of addr_ok low
    addr_lat = 3;
    data_en = 1'b1; data_we = 1'b1; data_size = 2'd0; data_sel = 4'b0100;
    data_addr = 32'h8000_0002; data_wdata = 32'h00AB_0000;
    push_req(1'b1, 2'd0, 4'b0100, 32'h8000_0002, 32'h00AB_0000);
    #1;
    for (int k = 1; k <= 3; k++) begin
      tick(); #1;
      chk("s_hold_fields", 64'({bus_req, bus_wr, bus_size, bus_sel, bus_addr}),
          64'({1'b1, 1'b1, 2'd0, 4'b0100, 32'h8000_0002}));
      chk("s_hold_wdata", 64'(bus_wdata), 64'h00AB_0000);
    end
    run(40, i_st, d_st, breq);
    chk("s_d_stall_cyc", 64'(d_st + 3), 64'd6);
    data_we = 1'b0;
    addr_lat = 0;

    // Redirect while a fetch is in I_WAIT
    data_lat = 2;
    inst_req = 1'b1; inst_addr = 32'h0000_0100;
    push_req(1'b0, 2'd2, 4'hF, 32'h0000_0100, 32'd0);
    push_req(1'b0, 2'd2, 4'hF, 32'hBFC0_0380, 32'd0);
    exp_i.push_back(mem_word(32'hBFC0_0380));
    #1;
    tick(); #1;
    chk("r_c1_addr", 64'(bus_addr), 64'h0000_0100);
    tick();
    inst_addr = 32'hBFC0_0380;
    #1;
    chk("r_c2_stall", 64'(inst_stall), 64'd1);
    tick(); tick(); tick(); #1;
    chk("r_c5_stale_miss", 64'(inst_stall), 64'd1);
    run(40, i_st, d_st, breq);
    chk("r_i_stall_cyc", 64'(i_st + 5), 64'd10);

    // Slow bus
    addr_lat = 5; data_lat = 7;
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    push_req(1'b0, 2'd2, 4'hF, 32'h0000_2000, 32'd0);
    exp_i.push_back(mem_word(32'h0000_2000));
    run(60, i_st, d_st, breq);
    chk("w_breq_cyc", 64'(breq), 64'd6);
    chk("w_i_stall_cyc", 64'(i_st), 64'd15);

    // Async reset during D_ADDR: bus_req drops without an edge, load reissues
    addr_lat = 4; data_lat = 0;
    data_en = 1'b1; data_size = 2'd2; data_sel = 4'hF; data_addr = 32'h8000_0040;
    push_req(1'b0, 2'd2, 4'hF, 32'h8000_0040, 32'd0);
    exp_d.push_back(mem_word(32'h8000_0040));
    tick(); #1;
    chk("a_c1_req", 64'(bus_req), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("a_req_async", 64'({bus_req, bus_addr}), 64'd0);
    chk("a_stall_held", 64'(data_stall), 64'd1);
    tick(); tick();
    rst = 1'b0;
    run(40, i_st, d_st, breq);

    // Async reset during D_WAIT
    addr_lat = 0; data_lat = 10;
    data_en = 1'b1; data_addr = 32'h8000_0044;
    push_req(1'b0, 2'd2, 4'hF, 32'h8000_0044, 32'd0);
    push_req(1'b0, 2'd2, 4'hF, 32'h8000_0044, 32'd0);
    exp_d.push_back(mem_word(32'h8000_0044));
    tick(); tick(); #1;
    chk("dw_state", 64'({bus_req, data_stall, bus_addr}), 64'h1_8000_0044);
    rst = 1'b1;
    #1;
    chk("dw_addr_async", 64'(bus_addr), 64'd0);
    data_lat = 0;
    tick(); tick();
    rst = 1'b0;
    run(40, i_st, d_st, breq);

    // Async reset clears a held buffer
    inst_consume = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_3000;
    push_req(1'b0, 2'd2, 4'hF, 32'h0000_3000, 32'd0);
    tick(); tick(); tick(); #1;
    chk("h_hit", 64'({inst_stall, inst_rdata}), 64'(mem_word(32'h0000_3000)));
    rst = 1'b1;
    #1;
    chk("h_done_async", 64'({inst_stall, inst_rdata}), 64'h1_0000_0000);
    inst_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    chk("left_req", 64'(exp_req.size()), 64'd0);
    chk("left_i", 64'(exp_i.size()), 64'd0);
    chk("left_d", 64'(exp_d.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/cpu_sram_arbiter.md
# cpu_sram_arbiter

Shares one SRAM-like bus between the core's instruction-fetch port and data-memory port, one transaction outstanding at a time, with data accesses given priority. Sits between `datapath` and the bus bridge/cache. Drives `stallreq_from_if` and `stallreq_from_mem` through `inst_stall` and `data_stall`. Holds each returned word in a tagged buffer until the pipeline consumes it.

## Interface
- No parameters; address/data 32 bits, fixed.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `inst_req` in 1: fetch wanted at `inst_addr`.
- `inst_addr` in 32: fetch address (`if_pc`).
- `inst_consume` in 1: IF stage advances this cycle (`~if_stall`).
- `inst_rdata` out 32: fetched word; valid while `inst_req & ~inst_stall`.
- `inst_stall` out 1: to `stallreq_from_if`.
- `data_en` in 1: data access wanted (`mem_en`).
- `data_we` in 1: store when 1.
- `data_size` in 2: 0=byte, 1=half, 2=word.
- `data_sel` in 4: byte strobes.
- `data_addr` in 32: access address.
- `data_wdata` in 32: store data.
- `data_consume` in 1: MEM stage advances this cycle (`~mem_stall`).
- `data_rdata` out 32: load word; valid while `data_en & ~data_stall`.
- `data_stall` out 1: to `stallreq_from_mem`.
- `bus_req` out 1: request valid.
- `bus_wr`, `bus_size[1:0]`, `bus_sel[3:0]`, `bus_addr[31:0]`, `bus_wdata[31:0]` out: request fields, held stable while `bus_req`.
- `bus_addr_ok` in 1: request accepted this cycle.
- `bus_data_ok` in 1: response/write completion this cycle.
- `bus_rdata` in 32: read data, valid with `bus_data_ok`.

## Operation
- FSM states: IDLE, I_ADDR, I_WAIT, D_ADDR, D_WAIT.
- Hit flags:
  - `i_hit = i_done_q & (i_tag_q == inst_addr)`.
  - `d_hit = d_done_q & (d_tag_q == data_addr)`.
- Pending flags:
  - `i_pend = inst_req & ~i_hit`.
  - `d_pend = data_en & ~d_hit`.
- Stall outputs (combinational, no path from `bus_*` inputs):
  - `inst_stall = i_pend`.
  - `data_stall = d_pend`.
- IDLE transitions:
  - `d_pend` → D_ADDR. Registers `data_*` fields onto `bus_*` and `d_tag_q <= data_addr`.
  - Else `i_pend` → I_ADDR. Registers `bus_wr=0`, `bus_size=2`, `bus_sel=4'hF`, `bus_addr=inst_addr`, `i_tag_q <= inst_addr`.
  - Data wins on a tie.
- X_ADDR: `bus_req=1`. On `bus_addr_ok` → X_WAIT with `bus_req=0`.
- X_WAIT: `bus_data_ok` is ignored in every state other than I_WAIT/D_WAIT. On `bus_data_ok`:
  - Capture `bus_rdata` into that side's buffer (stores capture too; value unused).
  - Set that side's `done_q`.
  - Return to IDLE.
- Clearing `done_q`:
  - `i_done_q` clears on `inst_consume & i_hit`.
  - `d_done_q` clears on `data_consume & d_hit`.
  - If set and clear coincide, set wins. Cannot occur legally, since that side was stalled.
- Flush/redirect: a transaction in flight always completes on the bus. A changed `inst_addr`/`data_addr` misses the tag, so the stale word is never delivered. The new request issues from IDLE afterwards.
- Data requests never pre-empt an in-flight fetch. Fetch waits while any data access is pending in IDLE.

## Timing
- Reset values:
  - FSM=IDLE.
  - `bus_req=0`, `bus_wr=0`, `bus_size=0`, `bus_sel=0`, `bus_addr=0`, `bus_wdata=0`.
  - `i_done_q=d_done_q=0`, tags=0, `inst_rdata=data_rdata=0`.
  - Stalls follow inputs (high when a request is presented).
- Reset mid-transaction drops the transaction immediately: `bus_req` falls asynchronously. The bus slave shares `rst`.
- Minimum miss latency, with `addr_ok` in the first X_ADDR cycle and `data_ok` in the first X_WAIT cycle:
  - Request at cycle 0 (IDLE).
  - `bus_req` in cycle 1.
  - X_WAIT in cycle 2.
  - IDLE with `done_q=1` and stall low in cycle 3.
- Back-to-back: the next request can leave IDLE in the cycle `done_q` rises.
- `data_ok` arriving in the same cycle as `addr_ok` is not supported. The bus guarantees `data_ok` no earlier than the cycle after `addr_ok`.

## Test plan
- Single fetch: `inst_req=1`, `inst_addr=0xBFC00000`; `addr_ok` in cycle 1, `data_ok`+`rdata=0x24080001` in cycle 2 → `inst_stall` high in cycles 0-2, low in cycle 3 with `inst_rdata=0x24080001`. `inst_consume` in cycle 3 → `i_done_q=0`.
- Contention: `inst_req` and `data_en` (load, addr 0x80000010) both raised at cycle 0 → D_ADDR first, `bus_addr=0x80000010`. The fetch issues only after D_WAIT completes. Fetch stall lasts ≥6 cycles.
- Store: `data_we=1`, `size=0`, `sel=4'b0100`, `addr=0x80000002`, `wdata=0x00AB0000` → bus carries exactly those fields, `bus_wr=1`. Fields stay stable over 3 cycles of `addr_ok=0`. `data_stall` falls after `data_ok`.
- Redirect: fetch to 0x100 in I_WAIT; `inst_addr` changes to 0xBFC00380 → 0x100 completes. `inst_stall` stays high. New fetch to 0xBFC00380 issues and is the one delivered.
- Slow bus: `addr_ok` delayed 5 cycles, `data_ok` delayed 7 cycles → `bus_req` high exactly 6 cycles. No second request issues. Stalls stay high throughout.
- Async reset asserted in D_WAIT → `bus_req`, `done_q` and state clear immediately without a clock edge. After release, a pending `data_en` reissues from IDLE.
